lsu_word_bridge: RTL and testbench
==================================

# lsu_word_bridge

Load/store unit that sits between the pipeline's MEM stage and the word-organised data memory. It accepts one load or store request at a time and drives the memory's write-enable/address/write-data/PC interface. Sub-word stores are built as read-modify-write sequences over the word-only memory. Load data is sign- or zero-extended, and misaligned accesses are flagged without touching memory.

## Interface
- ADDR_W, 32, byte address width; the memory word index is addr[ADDR_W-1:2].
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low; sampled on posedge clk.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_op  in  3  operation code: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; SH uses [15:0], SB uses [7:0].
- req_pc  in  32  PC of the instruction, forwarded to memory on writes.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores and misaligned accesses.
- resp_misalign  out  1  valid with resp_valid; access was misaligned and not performed.
- dm_we  out  1  memory write enable.
- dm_a  out  ADDR_W  memory byte address, always word-aligned (low 2 bits are 0).
- dm_wd  out  32  memory write data.
- dm_wpc  out  32  PC forwarded to memory.
- dm_rd  in  32  memory read data, combinational from dm_a.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- On accept, the unit registers op, addr, wdata and pc. Next state:
  - RESP if the access is misaligned. LW/SW are misaligned when addr[1:0] != 0; LH/LHU/SH when addr[0] != 0; byte ops are never misaligned.
  - READ for any load, SH or SB.
  - WRITE for SW.
- READ: the registered word is captured from dm_rd.
  - Loads: lane selected and extended into resp_rdata, then go to RESP.
  - SH/SB: the merged word is captured, then go to WRITE.
- Byte order is little-endian.
  - Byte lane k = bits [8k+7:8k], selected by addr[1:0].
  - Halfword lane = addr[1] ? [31:16] : [15:0].
- Extension:
  - LH and LB sign-extend.
  - LHU and LBU zero-extend.
  - LW passes the word through unchanged.
- Merge: only the selected lane is replaced with the low bits of wdata; the other bytes keep the value read from dm_rd.
- WRITE: dm_we = 1 for exactly one cycle. dm_wd is wdata for SW, the merged word for SH/SB. Then go to RESP.
- RESP: resp_valid = 1 for one cycle, then IDLE.
- dm_a = {addr[ADDR_W-1:2], 2'b00} in READ and WRITE, 0 otherwise. dm_wpc = registered pc.
- dm_we is gated by reset, so reset low forces dm_we = 0 in the same cycle.
- Misaligned requests never assert dm_we and never read memory.

## Timing
- Request accepted at edge T. Response timing:
  - Misaligned: resp_valid in cycle T+1.
  - SW, loads: resp_valid in cycle T+2.
  - SH, SB: resp_valid in cycle T+3.
- Issue rate: at most one outstanding request, so req_ready is low from T+1 until the cycle after RESP.
- Reset values (after any edge with reset = 0):
  - state IDLE, req_ready = 1
  - resp_valid = 0, resp_rdata = 0, resp_misalign = 0
  - dm_we = 0, dm_a = 0, dm_wd = 0, dm_wpc = 0
- Reset mid-operation: the operation is abandoned and no partial write occurs. A pending SH/SB write is dropped, and no resp_valid is issued for it.
- req_valid while busy is ignored. The requester holds its request until req_ready.
- resp_rdata and resp_misalign hold their last values outside RESP.

## Configuration
- LSU_TRACE_EN defined: every cycle with dm_we = 1 and reset high calls $display("@%h: *%h <= %h", dm_wpc, dm_a, dm_wd).
- LSU_TRACE_EN undefined: no display statements are compiled. Cycle behaviour is identical.

## Test plan
- SW 0x12345678 to 0x10, pc 0x3000: dm_we high exactly in T+1 with dm_a=0x10, dm_wd=0x12345678, dm_wpc=0x3000; resp_valid in T+2, resp_misalign=0.
- Word 0x11223344 at 0x10, then SB 0xAB to 0x13: READ in T+1, dm_we in T+2 with dm_wd=0xAB223344, resp_valid in T+3.
- Word 0xAB22F344 at 0x10:
  - LB 0x13 -> 0xFFFFFFAB; LBU 0x13 -> 0x000000AB.
  - LH 0x10 -> 0xFFFFF344; LHU 0x10 -> 0x0000F344.
  - All with resp_valid in T+2.
- LH 0x11 and SW 0x12: resp_valid in T+1 with resp_misalign=1 and resp_rdata=0; dm_we never asserted.
- SH 0xBEEF to 0x20, reset driven low in the READ cycle: dm_we stays 0, no resp_valid, req_ready=1 after the edge; word at 0x20 unchanged.
- Back-to-back requests with req_valid held high: the second is accepted only in the cycle after the first one's resp_valid.

Source files
------------

// File: rtl/lsu_word_bridge.sv
// lsu_word_bridge
// Load/store bridge between the MEM stage and a word-organised data memory.
// One request in flight at a time. Sub-word stores are done as a
// read-modify-write over the word-only memory; loads are lane-selected and
// sign/zero-extended; misaligned accesses complete without touching memory.
// Optional build macro: LSU_TRACE_EN -- when defined, every committed memory
// write is printed as "@<pc>: *<addr> <= <data>".
module lsu_word_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misalign,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_a,
    output logic [31:0]       dm_wd,
    output logic [31:0]       dm_wpc,
    input  logic [31:0]       dm_rd
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Loads occupy the low five opcodes.
    function automatic logic is_load(input logic [2:0] op);
        return (op <= OP_LBU);
    endfunction

    // Word ops need a 4-byte boundary, halfword ops a 2-byte boundary.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
        logic bad;
        case (op)
            OP_LW, OP_SW:          bad = (lo != 2'b00);
            OP_LH, OP_LHU, OP_SH:  bad = lo[0];
            default:               bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Little-endian byte lane k sits at bits [8k+7:8k].
    function automatic logic [7:0] byte_lane(input logic [1:0] lo, input logic [31:0] word);
        logic [7:0] b;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Select the addressed lane of the memory word and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = byte_lane(lo, word);
        h = lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LW:   r = word;
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the memory word with store data.
    function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [1:0] lo,
                                                input logic [31:0] word, input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        case (op)
            OP_SH: begin
                if (lo[1]) r[31:16] = wdata[15:0];
                else       r[15:0]  = wdata[15:0];
            end
            OP_SB: begin
                case (lo)
                    2'b00:   r[7:0]   = wdata[7:0];
                    2'b01:   r[15:8]  = wdata[7:0];
                    2'b10:   r[23:16] = wdata[7:0];
                    2'b11:   r[31:24] = wdata[7:0];
                    default: r = word;
                endcase
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [2:0]          op_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wd_r;
    logic [31:0]         pc_r;
    logic [31:0]         resp_rdata_r;
    logic                resp_misalign_r;
    logic                misalign_s;
    logic                dm_we_s;
    logic [ADDR_W-1:0]   dm_a_s;
    logic [31:0]         dm_wd_s;

    assign misalign_s = is_misaligned(req_op, req_addr[1:0]);

    // Next-state decode for the request sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (misalign_s)          state_s = ST_RESP;
                    else if (req_op == OP_SW) state_s = ST_WRITE;
                    else                      state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (is_load(op_r)) state_s = ST_RESP;
                else               state_s = ST_WRITE;
            end
            ST_WRITE: state_s = ST_RESP;
            ST_RESP:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register plus request capture, read capture and response data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            op_r            <= 3'b000;
            addr_r          <= {ADDR_W{1'b0}};
            wd_r            <= 32'h0000_0000;
            pc_r            <= 32'h0000_0000;
            resp_rdata_r    <= 32'h0000_0000;
            resp_misalign_r <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_r   <= req_op;
                        addr_r <= req_addr;
                        wd_r   <= req_wdata;
                        pc_r   <= req_pc;
                        if (misalign_s) begin
                            resp_rdata_r    <= 32'h0000_0000;
                            resp_misalign_r <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (is_load(op_r)) begin
                        resp_rdata_r    <= load_extend(op_r, addr_r[1:0], dm_rd);
                        resp_misalign_r <= 1'b0;
                    end else begin
                        wd_r <= store_merge(op_r, addr_r[1:0], dm_rd, wd_r);
                    end
                end
                ST_WRITE: begin
                    resp_rdata_r    <= 32'h0000_0000;
                    resp_misalign_r <= 1'b0;
                end
                default: begin
                    resp_rdata_r <= resp_rdata_r;
                end
            endcase
        end
    end

    // Memory-side drive; the write strobe drops in the same cycle reset falls.
    always_comb begin
        dm_we_s = 1'b0;
        dm_a_s  = {ADDR_W{1'b0}};
        dm_wd_s = 32'h0000_0000;
        if (state_r == ST_WRITE) begin
            dm_we_s = reset;
            dm_a_s  = {addr_r[ADDR_W-1:2], 2'b00};
            dm_wd_s = wd_r;
        end else if (state_r == ST_READ) begin
            dm_a_s  = {addr_r[ADDR_W-1:2], 2'b00};
        end else begin
            dm_we_s = 1'b0;
        end
    end

    assign req_ready     = (state_r == ST_IDLE);
    assign resp_valid    = (state_r == ST_RESP);
    assign resp_rdata    = resp_rdata_r;
    assign resp_misalign = resp_misalign_r;
    assign dm_we         = dm_we_s;
    assign dm_a          = dm_a_s;
    assign dm_wd         = dm_wd_s;
    assign dm_wpc        = pc_r;

`ifdef LSU_TRACE_EN
    // Print every committed memory write.
    always_ff @(posedge clk) begin
        if (dm_we) $display("@%h: *%h <= %h", dm_wpc, dm_a, dm_wd);
    end
`endif

endmodule

// File: tb/tb_lsu_word_bridge.sv
// Directed self-checking bench for lsu_word_bridge with a small word memory.
module tb_lsu_word_bridge;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        dm_we;
    logic [31:0] dm_a;
    logic [31:0] dm_wd;
    logic [31:0] dm_wpc;
    logic [31:0] dm_rd;

    int n_tests = 0;
    int n_fail  = 0;
    int we_count = 0;

    logic [31:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    lsu_word_bridge #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
        .dm_we(dm_we), .dm_a(dm_a), .dm_wd(dm_wd), .dm_wpc(dm_wpc), .dm_rd(dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, write on the rising edge.
    assign dm_rd = mem[dm_a[7:2]];
    always @(posedge clk) begin
        if (dm_we === 1'b1) begin
            mem[dm_a[7:2]] <= dm_wd;
            we_count <= we_count + 1;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk); pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk); pl_en = 1'b0;
    endtask

    // Present one request while idle; returns at the sampling point of cycle T+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] pc);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_pc = pc;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", resp_valid); end
        n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", resp_rdata); end
        n_tests++; if (resp_misalign !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b exp 0", resp_misalign); end
        n_tests++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b exp 0", dm_we); end
        n_tests++; if (dm_a !== 32'h0) begin n_fail++; $display("FAIL rst_a: got %h exp 0", dm_a); end
        n_tests++; if (dm_wd !== 32'h0) begin n_fail++; $display("FAIL rst_wd: got %h exp 0", dm_wd); end
        n_tests++; if (dm_wpc !== 32'h0) begin n_fail++; $display("FAIL rst_wpc: got %h exp 0", dm_wpc); end
        reset = 1'b1;
    endtask

    task automatic test_sw;
        issue(3'b101, 32'h10, 32'h12345678, 32'h3000);
        n_tests++; if (dm_we !== 1'b1) begin n_fail++; $display("FAIL sw_we_t1: got %b exp 1", dm_we); end
        n_tests++; if (dm_a !== 32'h10) begin n_fail++; $display("FAIL sw_a: got %h exp 10", dm_a); end
        n_tests++; if (dm_wd !== 32'h12345678) begin n_fail++; $display("FAIL sw_wd: got %h exp 12345678", dm_wd); end
        n_tests++; if (dm_wpc !== 32'h3000) begin n_fail++; $display("FAIL sw_wpc: got %h exp 3000", dm_wpc); end
        n_tests++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL sw_t1_flags: got ready=%b valid=%b exp 0 0", req_ready, resp_valid); end
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL sw_valid_t2: got %b exp 1", resp_valid); end
        n_tests++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL sw_we_t2: got %b exp 0", dm_we); end
        n_tests++; if (resp_misalign !== 1'b0 || resp_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_resp: got mis=%b rdata=%h exp 0 0", resp_misalign, resp_rdata); end
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL sw_t3: got valid=%b ready=%b exp 0 1", resp_valid, req_ready); end
        n_tests++; if (mem[4] !== 32'h12345678) begin n_fail++; $display("FAIL sw_mem: got %h exp 12345678", mem[4]); end
    endtask

    task automatic test_sb;
        preload(6'd4, 32'h11223344);
        issue(3'b111, 32'h13, 32'h000000AB, 32'h3004);
        n_tests++; if (dm_we !== 1'b0 || dm_a !== 32'h10) begin n_fail++; $display("FAIL sb_read: got we=%b a=%h exp 0 10", dm_we, dm_a); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL sb_valid_t1: got %b exp 0", resp_valid); end
        @(negedge clk);
        n_tests++; if (dm_we !== 1'b1) begin n_fail++; $display("FAIL sb_we_t2: got %b exp 1", dm_we); end
        n_tests++; if (dm_wd !== 32'hAB223344) begin n_fail++; $display("FAIL sb_wd: got %h exp ab223344", dm_wd); end
        n_tests++; if (dm_a !== 32'h10 || dm_wpc !== 32'h3004) begin n_fail++; $display("FAIL sb_a_pc: got %h %h exp 10 3004", dm_a, dm_wpc); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL sb_valid_t2: got %b exp 0", resp_valid); end
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1 || dm_we !== 1'b0) begin n_fail++; $display("FAIL sb_t3: got valid=%b we=%b exp 1 0", resp_valid, dm_we); end
        n_tests++; if (mem[4] !== 32'hAB223344) begin n_fail++; $display("FAIL sb_mem: got %h exp ab223344", mem[4]); end
        // Halfword store into the upper lane.
        issue(3'b110, 32'h12, 32'h0000BEEF, 32'h3008);
        @(negedge clk);
        n_tests++; if (dm_wd !== 32'hBEEF3344) begin n_fail++; $display("FAIL sh_wd: got %h exp beef3344", dm_wd); end
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL sh_valid_t3: got %b exp 1", resp_valid); end
    endtask

    task automatic test_loads;
        logic [2:0]  t_op  [0:6];
        logic [31:0] t_adr [0:6];
        logic [31:0] t_exp [0:6];
        t_op  = '{3'b011, 3'b100, 3'b001, 3'b010, 3'b000, 3'b011, 3'b001};
        t_adr = '{32'h13, 32'h13, 32'h10, 32'h10, 32'h10, 32'h11, 32'h12};
        t_exp = '{32'hFFFFFFAB, 32'h000000AB, 32'hFFFFF344, 32'h0000F344,
                  32'hAB22F344, 32'hFFFFFFF3, 32'hFFFFAB22};
        preload(6'd4, 32'hAB22F344);
        for (int i = 0; i < 7; i++) begin
            issue(t_op[i], t_adr[i], 32'h0, 32'h5000);
            n_tests++; if (resp_valid !== 1'b0 || dm_we !== 1'b0) begin n_fail++; $display("FAIL ld%0d_t1: got valid=%b we=%b exp 0 0", i, resp_valid, dm_we); end
            @(negedge clk);
            n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL ld%0d_valid: got %b exp 1", i, resp_valid); end
            n_tests++; if (resp_rdata !== t_exp[i]) begin n_fail++; $display("FAIL ld%0d_data: got %h exp %h", i, resp_rdata, t_exp[i]); end
            n_tests++; if (resp_misalign !== 1'b0) begin n_fail++; $display("FAIL ld%0d_mis: got %b exp 0", i, resp_misalign); end
        end
        @(negedge clk);
        n_tests++; if (resp_rdata !== 32'hFFFFAB22) begin n_fail++; $display("FAIL ld_hold: got %h exp ffffab22", resp_rdata); end
    endtask

    task automatic test_misalign;
        logic [2:0]  t_op  [0:2];
        logic [31:0] t_adr [0:2];
        int we_before;
        t_op  = '{3'b001, 3'b101, 3'b110};
        t_adr = '{32'h11, 32'h12, 32'h21};
        we_before = we_count;
        for (int i = 0; i < 3; i++) begin
            issue(t_op[i], t_adr[i], 32'hDEADBEEF, 32'h6000);
            n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL mis%0d_valid: got %b exp 1", i, resp_valid); end
            n_tests++; if (resp_misalign !== 1'b1) begin n_fail++; $display("FAIL mis%0d_flag: got %b exp 1", i, resp_misalign); end
            n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL mis%0d_data: got %h exp 0", i, resp_rdata); end
            n_tests++; if (dm_a !== 32'h0) begin n_fail++; $display("FAIL mis%0d_a: got %h exp 0", i, dm_a); end
            @(negedge clk);
            n_tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL mis%0d_idle: got ready=%b valid=%b exp 1 0", i, req_ready, resp_valid); end
        end
        n_tests++; if (we_count !== we_before) begin n_fail++; $display("FAIL mis_we: got %0d writes exp %0d", we_count, we_before); end
        n_tests++; if (mem[4] !== 32'hAB22F344) begin n_fail++; $display("FAIL mis_mem: got %h exp ab22f344", mem[4]); end
    endtask

    task automatic test_reset_mid;
        int we_before;
        logic seen;
        preload(6'd8, 32'h55667788);
        preload(6'd9, 32'h0BADF00D);
        we_before = we_count;
        issue(3'b110, 32'h20, 32'h0000BEEF, 32'h7000);
        n_tests++; if (dm_a !== 32'h20) begin n_fail++; $display("FAIL rm_read_a: got %h exp 20", dm_a); end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_after: got ready=%b valid=%b exp 1 0", req_ready, resp_valid); end
        n_tests++; if (dm_we !== 1'b0 || dm_a !== 32'h0 || dm_wpc !== 32'h0) begin n_fail++; $display("FAIL rm_mem_if: got we=%b a=%h pc=%h exp 0 0 0", dm_we, dm_a, dm_wpc); end
        reset = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || dm_we !== 1'b0) seen = 1'b1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rm_quiet: got activity=%b exp 0", seen); end
        // Reset falling during WRITE must kill the strobe in the same cycle.
        issue(3'b101, 32'h24, 32'h99999999, 32'h7004);
        n_tests++; if (dm_we !== 1'b1) begin n_fail++; $display("FAIL rm_sw_we: got %b exp 1", dm_we); end
        reset = 1'b0;
        #1;
        n_tests++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL rm_we_gate: got %b exp 0", dm_we); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_sw_valid: got %b exp 0", resp_valid); end
        n_tests++; if (mem[8] !== 32'h55667788) begin n_fail++; $display("FAIL rm_mem20: got %h exp 55667788", mem[8]); end
        n_tests++; if (mem[9] !== 32'h0BADF00D) begin n_fail++; $display("FAIL rm_mem24: got %h exp 0badf00d", mem[9]); end
        n_tests++; if (we_count !== we_before) begin n_fail++; $display("FAIL rm_we_cnt: got %0d exp %0d", we_count, we_before); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b000; req_addr = 32'h10; req_wdata = 32'h0; req_pc = 32'h8000;
        @(posedge clk);
        @(negedge clk);
        req_op = 3'b101; req_addr = 32'h28; req_wdata = 32'hCAFEF00D; req_pc = 32'h8004;
        n_tests++; if (req_ready !== 1'b0 || dm_we !== 1'b0) begin n_fail++; $display("FAIL b2b_t1: got ready=%b we=%b exp 0 0", req_ready, dm_we); end
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_t2: got valid=%b ready=%b exp 1 0", resp_valid, req_ready); end
        n_tests++; if (resp_rdata !== 32'hAB22F344) begin n_fail++; $display("FAIL b2b_data: got %h exp ab22f344", resp_rdata); end
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dm_we !== 1'b0) begin n_fail++; $display("FAIL b2b_t3: got ready=%b valid=%b we=%b exp 1 0 0", req_ready, resp_valid, dm_we); end
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++; if (dm_we !== 1'b1 || dm_a !== 32'h28) begin n_fail++; $display("FAIL b2b_t4: got we=%b a=%h exp 1 28", dm_we, dm_a); end
        n_tests++; if (dm_wd !== 32'hCAFEF00D || dm_wpc !== 32'h8004) begin n_fail++; $display("FAIL b2b_wd: got %h %h exp cafef00d 8004", dm_wd, dm_wpc); end
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_t5: got %b exp 1", resp_valid); end
        n_tests++; if (mem[10] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_mem: got %h exp cafef00d", mem[10]); end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_op = 3'b000; req_addr = 32'h0;
        req_wdata = 32'h0; req_pc = 32'h0; pl_en = 1'b0; pl_idx = 6'd0; pl_val = 32'h0;
        test_reset();
        test_sw();
        test_sb();
        test_loads();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
